// File: rtl/branch_resolve_unit.sv
// EX/MEM branch resolver: decodes ALU flags into a branch decision, registers the
// PC redirect, holds a multi-cycle flush of younger stages and keeps branch stats.
module branch_resolve_unit #(
    parameter int n            = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic             Zflag,
    input  logic             Vflag,
    input  logic             Sflag,
    input  logic             Cflag,
    input  logic [n-1:0]     pc,
    input  logic [n-1:0]     imm,
    input  logic [n-1:0]     alu_out,
    output logic             redirect_valid,
    output logic [n-1:0]     redirect_pc,
    output logic             flush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          accept, cond_ok, cond_true, counted, taken;
    logic [n-1:0]  target;

    always_comb begin
        cond_true = 1'b0;
        cond_ok   = 1'b1;
        case (funct3)
            3'b000:  cond_true = Zflag;
            3'b001:  cond_true = !Zflag;
            3'b100:  cond_true = Sflag != Vflag;
            3'b101:  cond_true = Sflag == Vflag;
            3'b110:  cond_true = !Cflag;
            3'b111:  cond_true = Cflag;
            default: cond_ok   = 1'b0;
        endcase
        accept  = in_valid && !stall && (state == IDLE);
        // jumps take priority, so a branch bit riding along with a jump is not counted
        counted = is_branch && !is_jal && !is_jalr && cond_ok;
        taken   = is_jalr || is_jal || (counted && cond_true);
        target  = is_jalr ? {alu_out[n-1:1], 1'b0} : pc + imm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            misalign_err   <= 1'b0;
            branch_cnt     <= '0;
            taken_cnt      <= '0;
        end else begin
            redirect_valid <= 1'b0;
            misalign_err   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (taken && !target[1]) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target;
                        flush          <= 1'b1;
                        state          <= FLUSH;
                        cnt            <= CW'(FLUSH_CYCLES - 1);
                    end else if (taken) begin
                        misalign_err   <= 1'b1;
                    end
                    if (counted) begin
                        if (branch_cnt != '1)
                            branch_cnt <= branch_cnt + 1'b1;
                        if (cond_true && taken_cnt != '1)
                            taken_cnt  <= taken_cnt + 1'b1;
                    end
                end
                FLUSH: if (!stall) begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        cnt   <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
